// File: rtl/mastermind_pkg.sv
// Shared definitions for the mastermind sequencer: sequencer states,
// code geometry (digit count and width) and the digit-slot index width.
package mastermind_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 3;
    localparam int IDX_W      = 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        CODE_ENTRY,
        GUESS_ENTRY,
        SCORE_REQ,
        SCORE_WAIT,
        WON,
        LOST
    } state_e;

endpackage

// File: rtl/mastermind_edge_detect.sv
// Registered rising-edge detector: remembers last cycle's level so a held
// input yields a single one-cycle rise indication.
module mastermind_edge_detect (
    input  logic clk,
    input  logic resetn,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // Capture the previous level of the input.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/mastermind_sequencer.sv
// Mastermind game sequencer: steers digit loads into the code/guess
// registers, requests scoring passes, tracks guesses and game status.
module mastermind_sequencer
    import mastermind_pkg::*;
#(
    parameter int MAX_GUESSES   = 8,
    parameter int SCORE_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               key_load,
    input  logic               new_game,
    input  logic [DIGIT_W-1:0] sw_digit,
    input  logic               score_done,
    input  logic [2:0]         score_red,
    input  logic [2:0]         score_white,
    output logic               wr_en,
    output logic               wr_sel,
    output logic [IDX_W-1:0]   wr_idx,
    output logic [DIGIT_W-1:0] wr_data,
    output logic               score_start,
    output logic [3:0]         guess_count,
    output logic [2:0]         fb_red,
    output logic [2:0]         fb_white,
    output logic               win,
    output logic               lose,
    output logic               err
);

    localparam int TMR_W = (SCORE_TIMEOUT > 1) ? $clog2(SCORE_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCORE_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wr_en_q, wr_en_d;
    logic               wr_sel_q, wr_sel_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [DIGIT_W-1:0] wr_data_q, wr_data_d;
    logic [3:0]         guess_cnt_q, guess_cnt_d;
    logic [2:0]         fb_red_q, fb_red_d;
    logic [2:0]         fb_white_q, fb_white_d;
    logic               err_q, err_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               rise;
    logic [3:0]         guess_cnt_inc;
    logic               score_bad;

    mastermind_edge_detect u_key_edge (
        .clk    (clk),
        .resetn (resetn),
        .sig_i  (key_load),
        .rise_o (rise)
    );

    assign guess_cnt_inc = guess_cnt_q + 4'd1;
    assign score_bad     = (score_red > 3'd4) ||
                           (({1'b0, score_red} + {1'b0, score_white}) > 4'd4);

    // Next-state logic: digit loading, scoring handshake, timeout and restart.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wr_en_d     = 1'b0;
        wr_sel_d    = wr_sel_q;
        wr_idx_d    = wr_idx_q;
        wr_data_d   = wr_data_q;
        guess_cnt_d = guess_cnt_q;
        fb_red_d    = fb_red_q;
        fb_white_d  = fb_white_q;
        err_d       = err_q;
        tmr_d       = tmr_q;

        case (state_q)
            CODE_ENTRY, GUESS_ENTRY: begin
                if (rise) begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = (state_q == GUESS_ENTRY);
                    wr_idx_d  = idx_q;
                    wr_data_d = sw_digit;
                    idx_d     = idx_q + IDX_W'(1);
                end
                // Leave only after the last digit's strobe so it never overlaps score_start.
                if (wr_en_q && (wr_idx_q == LAST_IDX)) begin
                    state_d = (state_q == CODE_ENTRY) ? GUESS_ENTRY : SCORE_REQ;
                end
            end
            SCORE_REQ: begin
                tmr_d   = '0;
                state_d = SCORE_WAIT;
            end
            SCORE_WAIT: begin
                if (score_done) begin
                    if (score_bad) begin
                        err_d   = 1'b1;
                        state_d = GUESS_ENTRY;
                    end else begin
                        fb_red_d    = score_red;
                        fb_white_d  = score_white;
                        guess_cnt_d = guess_cnt_inc;
                        if (score_red == 3'd4) begin
                            state_d = WON;
                        end else if (guess_cnt_inc == 4'(MAX_GUESSES)) begin
                            state_d = LOST;
                        end else begin
                            state_d = GUESS_ENTRY;
                        end
                    end
                end else if (tmr_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = GUESS_ENTRY;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            WON, LOST: begin
                state_d = state_q;
            end
            default: begin
                state_d = CODE_ENTRY;
            end
        endcase

        if (new_game) begin
            state_d     = CODE_ENTRY;
            idx_d       = '0;
            wr_en_d     = 1'b0;
            guess_cnt_d = '0;
            fb_red_d    = '0;
            fb_white_d  = '0;
            err_d       = 1'b0;
            tmr_d       = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= CODE_ENTRY;
            idx_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_sel_q    <= 1'b0;
            wr_idx_q    <= '0;
            wr_data_q   <= '0;
            guess_cnt_q <= '0;
            fb_red_q    <= '0;
            fb_white_q  <= '0;
            err_q       <= 1'b0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wr_en_q     <= wr_en_d;
            wr_sel_q    <= wr_sel_d;
            wr_idx_q    <= wr_idx_d;
            wr_data_q   <= wr_data_d;
            guess_cnt_q <= guess_cnt_d;
            fb_red_q    <= fb_red_d;
            fb_white_q  <= fb_white_d;
            err_q       <= err_d;
            tmr_q       <= tmr_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_sel      = wr_sel_q;
    assign wr_idx      = wr_idx_q;
    assign wr_data     = wr_data_q;
    assign score_start = (state_q == SCORE_REQ);
    assign guess_count = guess_cnt_q;
    assign fb_red      = fb_red_q;
    assign fb_white    = fb_white_q;
    assign win         = (state_q == WON);
    assign lose        = (state_q == LOST);
    assign err         = err_q;

endmodule

// File: tb/tb_mastermind_sequencer.sv
// Directed self-checking bench for the mastermind sequencer.
module tb_mastermind_sequencer;

    logic       clk;
    logic       resetn;
    logic       key_load;
    logic       new_game;
    logic [2:0] sw_digit;
    logic       score_done;
    logic [2:0] score_red;
    logic [2:0] score_white;
    logic       wr_en;
    logic       wr_sel;
    logic [1:0] wr_idx;
    logic [2:0] wr_data;
    logic       score_start;
    logic [3:0] guess_count;
    logic [2:0] fb_red;
    logic [2:0] fb_white;
    logic       win;
    logic       lose;
    logic       err;

    int testsRun;
    int testsFailed;

    mastermind_sequencer #(
        .MAX_GUESSES   (8),
        .SCORE_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .key_load    (key_load),
        .new_game    (new_game),
        .sw_digit    (sw_digit),
        .score_done  (score_done),
        .score_red   (score_red),
        .score_white (score_white),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .score_start (score_start),
        .guess_count (guess_count),
        .fb_red      (fb_red),
        .fb_white    (fb_white),
        .win         (win),
        .lose        (lose),
        .err         (err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic keyLoad, input logic newGame, input logic [2:0] digit);
        key_load = keyLoad;
        new_game = newGame;
        sw_digit = digit;
    endtask

    // One press/release of the load key; the strobe must appear the next cycle.
    task automatic pressDigit(input logic [2:0] digit, input logic expSel, input logic [1:0] expIdx);
        applyStimulus(1'b1, 1'b0, digit);
        tick();
        checkOutput("wrEn", 32'(wr_en), 32'd1);
        checkOutput("wrSel", 32'(wr_sel), 32'(expSel));
        checkOutput("wrIdx", 32'(wr_idx), 32'(expIdx));
        checkOutput("wrData", 32'(wr_data), 32'(digit));
        checkOutput("scoreStartDuringWr", 32'(score_start), 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0);
        tick();
        checkOutput("wrEnOnePulse", 32'(wr_en), 32'd0);
    endtask

    // Four digits, least-significant octal digit is slot 0.
    task automatic loadWord(input logic sel, input logic [11:0] digits);
        for (int i = 0; i < 4; i++) begin
            pressDigit(digits[i*3 +: 3], sel, 2'(i));
        end
        if (sel) begin
            checkOutput("scoreStartAfterGuess", 32'(score_start), 32'd1);
        end
    endtask

    // Called in the score_start cycle: answer after one wait cycle.
    task automatic scoreGuess(input logic [2:0] red, input logic [2:0] white);
        tick();
        score_red   = red;
        score_white = white;
        score_done  = 1'b1;
        tick();
        score_done  = 1'b0;
        score_red   = 3'd0;
        score_white = 3'd0;
    endtask

    task automatic newGame();
        applyStimulus(1'b0, 1'b1, 3'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        int pulses;
        logic [2:0] seenData;

        testsRun    = 0;
        testsFailed = 0;
        resetn      = 1'b0;
        score_done  = 1'b0;
        score_red   = 3'd0;
        score_white = 3'd0;
        applyStimulus(1'b0, 1'b0, 3'd0);

        // Reset state.
        #3;
        checkOutput("rstWrEn", 32'(wr_en), 32'd0);
        checkOutput("rstScoreStart", 32'(score_start), 32'd0);
        checkOutput("rstGuessCount", 32'(guess_count), 32'd0);
        checkOutput("rstWin", 32'(win), 32'd0);
        checkOutput("rstErr", 32'(err), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Code 1,2,3,4 then a held key loads once (guess slot 0).
        loadWord(1'b0, 12'o4321);
        applyStimulus(1'b1, 1'b0, 3'd5);
        pulses   = 0;
        seenData = 3'd0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (wr_en) begin
                pulses++;
                seenData = wr_data;
                checkOutput("holdSel", 32'(wr_sel), 32'd1);
                checkOutput("holdIdx", 32'(wr_idx), 32'd0);
            end
        end
        applyStimulus(1'b0, 1'b0, 3'd0);
        tick();
        checkOutput("holdPulses", 32'(pulses), 32'd1);
        checkOutput("holdData", 32'(seenData), 32'd5);

        // Finish the guess, score red=4 three cycles after score_start.
        pressDigit(3'd6, 1'b1, 2'd1);
        pressDigit(3'd7, 1'b1, 2'd2);
        pressDigit(3'd0, 1'b1, 2'd3);
        checkOutput("scoreStartWin", 32'(score_start), 32'd1);
        tick();
        checkOutput("scoreStartPulse", 32'(score_start), 32'd0);
        tick();
        tick();
        score_red  = 3'd4;
        score_done = 1'b1;
        tick();
        score_done = 1'b0;
        score_red  = 3'd0;
        checkOutput("winFbRed", 32'(fb_red), 32'd4);
        checkOutput("winCount", 32'(guess_count), 32'd1);
        checkOutput("win", 32'(win), 32'd1);
        applyStimulus(1'b1, 1'b0, 3'd3);
        tick();
        checkOutput("wonNoWr", 32'(wr_en), 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0);
        tick();
        checkOutput("wonNoWr2", 32'(wr_en), 32'd0);
        checkOutput("winHeld", 32'(win), 32'd1);

        // New game, eight red=1 white=2 guesses lead to a loss.
        newGame();
        checkOutput("ngWin", 32'(win), 32'd0);
        checkOutput("ngCount", 32'(guess_count), 32'd0);
        checkOutput("ngFbRed", 32'(fb_red), 32'd0);
        loadWord(1'b0, 12'o1234);
        for (int g = 0; g < 8; g++) begin
            loadWord(1'b1, 12'o0123);
            scoreGuess(3'd1, 3'd2);
            checkOutput("loseCount", 32'(guess_count), 32'(g + 1));
            checkOutput("loseFbRed", 32'(fb_red), 32'd1);
            checkOutput("loseFbWhite", 32'(fb_white), 32'd2);
            checkOutput("loseFlag", 32'(lose), 32'(g == 7));
        end
        checkOutput("loseNoWin", 32'(win), 32'd0);

        // Timeout: SCORE_WAIT lasts 16 cycles with no answer.
        newGame();
        checkOutput("ngLose", 32'(lose), 32'd0);
        loadWord(1'b0, 12'o7777);
        loadWord(1'b1, 12'o1111);
        for (int k = 0; k < 16; k++) begin
            tick();
        end
        checkOutput("toErrEarly", 32'(err), 32'd0);
        tick();
        checkOutput("toErr", 32'(err), 32'd1);
        checkOutput("toCount", 32'(guess_count), 32'd0);
        pressDigit(3'd2, 1'b1, 2'd0);
        pressDigit(3'd2, 1'b1, 2'd1);
        pressDigit(3'd2, 1'b1, 2'd2);
        pressDigit(3'd2, 1'b1, 2'd3);
        checkOutput("toScoreStart", 32'(score_start), 32'd1);
        scoreGuess(3'd2, 3'd1);
        checkOutput("validFbRed", 32'(fb_red), 32'd2);
        checkOutput("validCount", 32'(guess_count), 32'd1);
        loadWord(1'b1, 12'o3333);
        scoreGuess(3'd5, 3'd0);
        checkOutput("badRedErr", 32'(err), 32'd1);
        checkOutput("badRedFb", 32'(fb_red), 32'd2);
        checkOutput("badRedCount", 32'(guess_count), 32'd1);
        loadWord(1'b1, 12'o4444);
        scoreGuess(3'd3, 3'd2);
        checkOutput("badSumFbRed", 32'(fb_red), 32'd2);
        checkOutput("badSumFbWhite", 32'(fb_white), 32'd1);
        checkOutput("badSumCount", 32'(guess_count), 32'd1);

        // new_game together with a rise mid-guess.
        pressDigit(3'd1, 1'b1, 2'd0);
        pressDigit(3'd1, 1'b1, 2'd1);
        applyStimulus(1'b1, 1'b1, 3'd6);
        tick();
        checkOutput("ngRiseWrEn", 32'(wr_en), 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0);
        tick();
        checkOutput("ngRiseWrEn2", 32'(wr_en), 32'd0);
        checkOutput("ngRiseCount", 32'(guess_count), 32'd0);
        checkOutput("ngRiseErr", 32'(err), 32'd0);
        checkOutput("ngRiseFbWhite", 32'(fb_white), 32'd0);
        pressDigit(3'd3, 1'b0, 2'd0);

        // Reset while waiting for a score.
        pressDigit(3'd3, 1'b0, 2'd1);
        pressDigit(3'd3, 1'b0, 2'd2);
        pressDigit(3'd3, 1'b0, 2'd3);
        loadWord(1'b1, 12'o5555);
        scoreGuess(3'd1, 3'd1);
        checkOutput("preRstCount", 32'(guess_count), 32'd1);
        loadWord(1'b1, 12'o6666);
        tick();
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("asyncRstCount", 32'(guess_count), 32'd0);
        checkOutput("asyncRstFbRed", 32'(fb_red), 32'd0);
        checkOutput("asyncRstFbWhite", 32'(fb_white), 32'd0);
        checkOutput("asyncRstWrEn", 32'(wr_en), 32'd0);
        resetn = 1'b1;
        tick();
        checkOutput("postRstWrEn", 32'(wr_en), 32'd0);
        checkOutput("postRstScoreStart", 32'(score_start), 32'd0);
        tick();
        checkOutput("postRstErr", 32'(err), 32'd0);
        pressDigit(3'd4, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
